// File: rtl/decoder_gate_scheduler.sv
// decoder_gate_scheduler: round-robin arbiter sharing one decoder-based NAND/NOR evaluator among 4 requesters.
// Optional DECSCHED_STATS_EN adds an 8-bit txn_count of issued responses.
module decoder_gate_scheduler #(
    parameter int EVAL_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] req_a,
    input  logic [3:0] req_b,
    input  logic [3:0] req_op,
    output logic [3:0] gnt,
    output logic [3:0] rsp_valid,
    output logic       rsp_data,
    output logic       busy
`ifdef DECSCHED_STATS_EN
    ,
    output logic [7:0] txn_count
`endif
);
    localparam int         EVC     = EVAL_CYCLES < 1 ? 1 : (EVAL_CYCLES > 15 ? 15 : EVAL_CYCLES);
    localparam logic [3:0] EV_LOAD = 4'(EVC - 1);

    typedef enum logic [1:0] {IDLE, GRANT, EVAL, RESP} state_t;

    state_t     state_q, state_d;
    logic [1:0] last_q, last_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       a_q, a_d, b_q, b_d, op_q, op_d, data_q, data_d;
    logic [1:0] win, probe;
    logic       hit;
    logic [3:0] y;
    logic       result;

    function automatic logic [3:0] dec2(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

    // Search starts just after the last winner, so the previous winner ranks lowest.
    always_comb begin
        win   = last_q;
        hit   = 1'b0;
        probe = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            probe = last_q + 2'(k);
            if (!hit && req[probe]) begin
                win = probe;
                hit = 1'b1;
            end
        end
    end

    assign y      = dec2({a_q, b_q});
    assign result = op_q ? y[0] : ~y[3];

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        data_d  = data_q;
        case (state_q)
            IDLE: if (hit) begin
                idx_d   = win;
                a_d     = req_a[win];
                b_d     = req_b[win];
                op_d    = req_op[win];
                state_d = GRANT;
            end
            GRANT: begin
                cnt_d   = EV_LOAD;
                state_d = EVAL;
            end
            EVAL: if (cnt_q == 4'd0) begin
                data_d  = result;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            RESP: begin
                last_d  = idx_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            op_q    <= 1'b0;
            data_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            data_q  <= data_d;
        end
    end

    assign gnt       = state_q == GRANT ? dec2(idx_q) : 4'b0000;
    assign rsp_valid = state_q == RESP ? dec2(idx_q) : 4'b0000;
    assign rsp_data  = data_q;
    assign busy      = state_q != IDLE;

`ifdef DECSCHED_STATS_EN
    logic [7:0] txn_q, txn_d;

    always_comb txn_d = state_q == RESP ? txn_q + 8'd1 : txn_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) txn_q <= 8'd0;
        else txn_q <= txn_d;
    end

    assign txn_count = txn_q;
`endif
endmodule
